result_unloader: RTL and testbench
==================================

RESULT_UNLOADER -- requirements
Module: result_unloader

Interface
REQ-001 Parameter WORD_SIZE, default `WORD_SIZE, data word width.
REQ-002 Parameter RAM_ADDR_SIZE, default `RAM_ADDR_SIZE, result RAM address width.
REQ-003 Parameter START_ADDR, default `RAM_G, address of the first result word.
REQ-004 Parameter NUM_WORDS, default 12, words to unload; SHALL be even and at least 2.
REQ-005 clk  input  1  single clock, all state on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 start  input  1  one-cycle request to unload the result.
REQ-008 is_busy  input  1  core busy flag from top.
REQ-009 outdata1, outdata2  input  WORD_SIZE each  top read ports, valid one cycle after address.
REQ-010 o_ref_mode  output  1  high requests top input mode `REF_RESULT.
REQ-011 o_raddr1, o_raddr2  output  RAM_ADDR_SIZE each  read addresses to top.
REQ-012 m_valid, m_data, m_last  output  1 / WORD_SIZE / 1  result word stream.
REQ-013 m_idx  output  4  index of the current word, 0..NUM_WORDS-1.
REQ-014 m_ready  input  1  stream sink accepts a word.
REQ-015 o_busy, o_done, o_err  output  1 each  active / one-cycle completion pulse / sticky abort flag.

Function
REQ-016 States SHALL be IDLE, WAIT_CORE, READ, CAP, SEND0, SEND1, DONE; pair counter k runs 0..NUM_WORDS/2-1.
REQ-017 IDLE: start -> WAIT_CORE, k=0, o_err cleared; start is ignored in every other state.
REQ-018 WAIT_CORE: stay while is_busy=1; is_busy=0 -> READ.
REQ-019 READ and CAP: o_ref_mode=1, o_raddr1=START_ADDR+2k, o_raddr2=START_ADDR+2k+1, with addresses registered and stable across both cycles.
REQ-020 READ -> CAP unconditionally; at the end of CAP, outdata1 and outdata2 SHALL be captured into word regs A and B, then -> SEND0.
REQ-021 If is_busy=1 in READ or CAP: o_err<=1, no capture, -> IDLE, and no o_done.
REQ-022 SEND0: m_valid=1, m_data=A, m_idx=2k; hold until m_ready, then -> SEND1.
REQ-023 SEND1: m_valid=1, m_data=B, m_idx=2k+1, m_last=1 when k=NUM_WORDS/2-1; on m_ready, last pair -> DONE, otherwise k+1 -> READ.
REQ-024 Once m_valid is asserted, m_data, m_idx and m_last SHALL stay stable until the handshake; is_busy is ignored in the SEND states.
REQ-025 DONE: o_done=1 for exactly one cycle, then -> IDLE.
REQ-026 o_busy=1 in every state except IDLE; m_valid=0 outside SEND0/SEND1; o_ref_mode=0 outside READ/CAP.
REQ-027 Address arithmetic SHALL be modulo 2^RAM_ADDR_SIZE (wrap, no error).
REQ-028 Latency with is_busy=0 and m_ready=1, start sampled at cycle 0: WAIT_CORE 1, READ 2+4k, CAP 3+4k, SEND0 4+4k, SEND1 5+4k. For NUM_WORDS=12, the first m_valid is at cycle 4, m_last at cycle 25, and o_done at cycle 26.

Reset
REQ-029 With rst=1 at a clock edge, the state SHALL go to IDLE, k=0, and every output SHALL be 0, including o_err, A and B.
REQ-030 Reset mid-operation SHALL abort immediately with no o_done; a start in the same cycle as rst is ignored.

Verification
REQ-031 Preload RAM with START_ADDR+i -> 0xA0+i, is_busy=0, m_ready=1, pulse start -> 12 words 0xA0..0xAB with m_idx 0..11, m_last only on idx 11, o_done at cycle 26.
REQ-032 is_busy=1 for 100 cycles after start -> o_ref_mode stays 0 throughout, READ on the cycle after is_busy falls, and the stream is otherwise identical to REQ-031.
REQ-033 m_ready random 30% duty -> the same 12 words in order, with m_data, m_idx and m_last held while m_valid=1 and m_ready=0.
REQ-034 is_busy rises during CAP of pair 2 -> o_err=1, return to IDLE, no o_done; a new start clears o_err and completes normally.
REQ-035 rst asserted during SEND1 of pair 3 -> next cycle all outputs 0; a second start pulse while o_busy=1 has no effect.
REQ-036 START_ADDR=2^RAM_ADDR_SIZE-4 -> addresses wrap to 0 at pair 2, and the data order is preserved.

Source files
------------

// File: rtl/result_unloader_if.sv
// Result word stream between result_unloader and its sink.
// The unloader drives the word, its index and last flag; the sink answers with m_ready.
interface result_unloader_if #(
    parameter int WORD_SIZE = 16
);
    logic                 m_valid;
    logic [WORD_SIZE-1:0] m_data;
    logic                 m_last;
    logic [3:0]           m_idx;
    logic                 m_ready;

    modport master (
        output m_valid,
        output m_data,
        output m_last,
        output m_idx,
        input  m_ready
    );

    modport slave (
        input  m_valid,
        input  m_data,
        input  m_last,
        input  m_idx,
        output m_ready
    );
endinterface

// File: rtl/result_unloader.sv
// Result unloader: waits for the core to go idle, reads the result RAM two words
// at a time through the top-level read ports and streams the words out in order.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | waiting for a start request
// WAIT_CORE | start seen, waiting for the core busy flag to drop
// READ      | read addresses for pair k presented, ref mode requested
// CAP       | RAM data for pair k valid, captured into A/B at the edge
// SEND0     | word A (index 2k) offered on the stream
// SEND1     | word B (index 2k+1) offered, last flag on the final pair
// DONE      | one-cycle completion pulse

`ifndef WORD_SIZE
`define WORD_SIZE 16
`endif
`ifndef RAM_ADDR_SIZE
`define RAM_ADDR_SIZE 8
`endif
`ifndef RAM_G
`define RAM_G 16
`endif

module result_unloader #(
    parameter int WORD_SIZE     = `WORD_SIZE,
    parameter int RAM_ADDR_SIZE = `RAM_ADDR_SIZE,
    parameter int START_ADDR    = `RAM_G,
    // Must be even, at least 2 and at most 16 (m_idx is four bits wide).
    parameter int NUM_WORDS     = 12
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     is_busy,
    input  logic [WORD_SIZE-1:0]     outdata1,
    input  logic [WORD_SIZE-1:0]     outdata2,
    output logic                     o_ref_mode,
    output logic [RAM_ADDR_SIZE-1:0] o_raddr1,
    output logic [RAM_ADDR_SIZE-1:0] o_raddr2,
    result_unloader_if.master        m_stream,
    output logic                     o_busy,
    output logic                     o_done,
    output logic                     o_err
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_CORE = 3'd1,
        READ      = 3'd2,
        CAP       = 3'd3,
        SEND0     = 3'd4,
        SEND1     = 3'd5,
        DONE      = 3'd6
    } state_t;

    localparam int                     PAIRS  = NUM_WORDS / 2;
    localparam logic [2:0]             LAST_K = 3'(PAIRS - 1);
    localparam logic [RAM_ADDR_SIZE-1:0] BASE = RAM_ADDR_SIZE'(START_ADDR);
    // Address arithmetic is deliberately width-truncated so reads wrap around the RAM.
    localparam logic [RAM_ADDR_SIZE-1:0] ONE  = RAM_ADDR_SIZE'(1);
    localparam logic [RAM_ADDR_SIZE-1:0] TWO  = RAM_ADDR_SIZE'(2);

    state_t                   state;
    state_t                   state_nxt;
    logic [2:0]               k;
    logic [RAM_ADDR_SIZE-1:0] raddr1_q;
    logic [RAM_ADDR_SIZE-1:0] raddr2_q;
    logic [WORD_SIZE-1:0]     word_a;
    logic [WORD_SIZE-1:0]     word_b;
    logic                     err_q;
    logic                     last_pair;

    assign last_pair = (k == LAST_K);

    // State register; reset wins over any start in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; a busy core during the read aborts back to IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = WAIT_CORE;
                end
            end
            WAIT_CORE: begin
                if (!is_busy) begin
                    state_nxt = READ;
                end
            end
            READ: begin
                state_nxt = is_busy ? IDLE : CAP;
            end
            CAP: begin
                state_nxt = is_busy ? IDLE : SEND0;
            end
            SEND0: begin
                if (m_stream.m_ready) begin
                    state_nxt = SEND1;
                end
            end
            SEND1: begin
                if (m_stream.m_ready) begin
                    state_nxt = last_pair ? DONE : READ;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Pair counter, registered read addresses, captured words and sticky error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            k        <= 3'd0;
            raddr1_q <= '0;
            raddr2_q <= '0;
            word_a   <= '0;
            word_b   <= '0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        k        <= 3'd0;
                        raddr1_q <= BASE;
                        raddr2_q <= BASE + ONE;
                        err_q    <= 1'b0;
                    end
                end
                READ: begin
                    if (is_busy) begin
                        err_q <= 1'b1;
                    end
                end
                CAP: begin
                    if (is_busy) begin
                        err_q <= 1'b1;
                    end else begin
                        word_a <= outdata1;
                        word_b <= outdata2;
                    end
                end
                SEND1: begin
                    if (m_stream.m_ready && !last_pair) begin
                        k        <= k + 3'd1;
                        raddr1_q <= raddr1_q + TWO;
                        raddr2_q <= raddr2_q + TWO;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs are decoded from the registered state so they are quiet after reset.
    always_comb begin
        o_ref_mode       = 1'b0;
        o_raddr1         = '0;
        o_raddr2         = '0;
        m_stream.m_valid = 1'b0;
        m_stream.m_data  = '0;
        m_stream.m_last  = 1'b0;
        m_stream.m_idx   = 4'd0;
        o_busy           = (state != IDLE);
        o_done           = 1'b0;
        o_err            = err_q;
        case (state)
            READ, CAP: begin
                o_ref_mode = 1'b1;
                o_raddr1   = raddr1_q;
                o_raddr2   = raddr2_q;
            end
            SEND0: begin
                m_stream.m_valid = 1'b1;
                m_stream.m_data  = word_a;
                m_stream.m_idx   = {k, 1'b0};
            end
            SEND1: begin
                m_stream.m_valid = 1'b1;
                m_stream.m_data  = word_b;
                m_stream.m_idx   = {k, 1'b1};
                m_stream.m_last  = last_pair;
            end
            DONE: begin
                o_done = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_result_unloader.sv
// Testbench for result_unloader: table-driven unload jobs, random jobs and
// hand-written abort/reset sequences, checked against a word-list model.
`timescale 1ns/1ps
module tb_result_unloader;

    localparam int WS = 16;
    localparam int AS = 8;
    localparam int NW = 12;
    localparam int START_M = 16;
    localparam int START_W = 252;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          is_busy;
    logic          m_ready;
    logic          sel;
    logic [WS-1:0] mem [256];

    logic          start_m, start_w;
    logic [WS-1:0] rd1_m, rd2_m, rd1_w, rd2_w;
    logic [AS-1:0] ra1_m, ra2_m, ra1_w, ra2_w;
    logic          ref_m, ref_w, busy_m, busy_w, done_m, done_w, err_m, err_w;

    result_unloader_if #(.WORD_SIZE(WS)) bus_m ();
    result_unloader_if #(.WORD_SIZE(WS)) bus_w ();

    assign start_m       = start & ~sel;
    assign start_w       = start & sel;
    assign bus_m.m_ready = m_ready;
    assign bus_w.m_ready = m_ready;

    result_unloader #(.WORD_SIZE(WS), .RAM_ADDR_SIZE(AS), .START_ADDR(START_M), .NUM_WORDS(NW)) u_main (
        .clk(clk), .rst(rst), .start(start_m), .is_busy(is_busy),
        .outdata1(rd1_m), .outdata2(rd2_m), .o_ref_mode(ref_m),
        .o_raddr1(ra1_m), .o_raddr2(ra2_m), .m_stream(bus_m),
        .o_busy(busy_m), .o_done(done_m), .o_err(err_m)
    );

    result_unloader #(.WORD_SIZE(WS), .RAM_ADDR_SIZE(AS), .START_ADDR(START_W), .NUM_WORDS(NW)) u_wrap (
        .clk(clk), .rst(rst), .start(start_w), .is_busy(is_busy),
        .outdata1(rd1_w), .outdata2(rd2_w), .o_ref_mode(ref_w),
        .o_raddr1(ra1_w), .o_raddr2(ra2_w), .m_stream(bus_w),
        .o_busy(busy_w), .o_done(done_w), .o_err(err_w)
    );

    always #5 clk = ~clk;

    // Result RAM: read data appears one cycle after the address.
    always @(posedge clk) begin
        rd1_m <= mem[ra1_m];
        rd2_m <= mem[ra2_m];
        rd1_w <= mem[ra1_w];
        rd2_w <= mem[ra2_w];
    end

    logic          obs_valid, obs_last, obs_ref, obs_busy, obs_done, obs_err;
    logic [WS-1:0] obs_data;
    logic [3:0]    obs_idx;
    logic [AS-1:0] obs_ra1, obs_ra2;

    always_comb begin
        obs_valid = sel ? bus_w.m_valid : bus_m.m_valid;
        obs_data  = sel ? bus_w.m_data  : bus_m.m_data;
        obs_idx   = sel ? bus_w.m_idx   : bus_m.m_idx;
        obs_last  = sel ? bus_w.m_last  : bus_m.m_last;
        obs_ref   = sel ? ref_w  : ref_m;
        obs_ra1   = sel ? ra1_w  : ra1_m;
        obs_ra2   = sel ? ra2_w  : ra2_m;
        obs_busy  = sel ? busy_w : busy_m;
        obs_done  = sel ? done_w : done_m;
        obs_err   = sel ? err_w  : err_m;
    end

    int checks = 0;
    int failures = 0;

    // model / tracking state
    int            nrecv;
    int            ready_pct;
    int            first_valid_t, first_ref_t, done_t, done_cnt;
    bit            prev_stall;
    logic [WS-1:0] pv_data;
    logic [3:0]    pv_idx;
    logic          pv_last;

    typedef struct {
        int hold;
        int pct;
        int exp_first;
        int exp_done;
        bit sel;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic int base_addr();
        return sel ? START_W : START_M;
    endfunction

    task automatic reset_track();
        nrecv         = 0;
        prev_stall    = 0;
        first_valid_t = -1;
        first_ref_t   = -1;
        done_t        = -1;
        done_cnt      = 0;
    endtask

    // Called at a negedge for cycle t: picks m_ready, then checks the cycle's outputs.
    task automatic cycle_step(input int t);
        bit rdy;
        rdy = ($urandom_range(0, 99) < ready_pct);
        m_ready = rdy;
        if (prev_stall) begin
            check("hold_valid", 32'(obs_valid), 32'd1);
            check("hold_data", 32'(obs_data), 32'(pv_data));
            check("hold_idx", 32'(obs_idx), 32'(pv_idx));
            check("hold_last", 32'(obs_last), 32'(pv_last));
        end
        if (obs_ref) begin
            if (first_ref_t < 0) first_ref_t = t;
            check("raddr1", 32'(obs_ra1), 32'((base_addr() + 2 * (nrecv / 2)) % 256));
            check("raddr2", 32'(obs_ra2), 32'((base_addr() + 2 * (nrecv / 2) + 1) % 256));
        end
        if (obs_valid) begin
            if (first_valid_t < 0) first_valid_t = t;
            if (rdy) begin
                check("word_data", 32'(obs_data), 32'(16'h00A0 + nrecv));
                check("word_idx", 32'(obs_idx), 32'(nrecv));
                check("word_last", 32'(obs_last), 32'(nrecv == NW - 1));
                nrecv++;
            end
        end
        prev_stall = obs_valid && !rdy;
        pv_data = obs_data;
        pv_idx  = obs_idx;
        pv_last = obs_last;
        if (obs_done) begin
            done_cnt++;
            done_t = t;
            check("done_words", 32'(nrecv), 32'(NW));
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_job(input int hold, input int pct, input int exp_first, input int exp_done, input bit s);
        sel = s;
        reset_track();
        ready_pct = pct;
        is_busy = 1'b1;
        pulse_start();
        for (int t = 1; t <= 3000; t++) begin
            if (t == hold) is_busy = 1'b0;
            if (t == 1) check("err_cleared", 32'(obs_err), 32'd0);
            if (t <= hold) check("ref_while_busy", 32'(obs_ref), 32'd0);
            cycle_step(t);
            if (done_t >= 0) break;
            @(negedge clk);
        end
        is_busy = 1'b0;
        check("done_count", 32'(done_cnt), 32'd1);
        check("words_total", 32'(nrecv), 32'(NW));
        check("first_read", 32'(first_ref_t), 32'(hold + 1));
        check("first_valid", 32'(first_valid_t), 32'(exp_first));
        if (exp_done != 0) check("done_cycle", 32'(done_t), 32'(exp_done));
        @(negedge clk);
        check("done_pulse_end", 32'(obs_done), 32'd0);
        check("idle_after", 32'(obs_busy), 32'd0);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{hold: 1,   pct: 100, exp_first: 4,   exp_done: 26,  sel: 1'b0};
        vecs[1] = '{hold: 100, pct: 100, exp_first: 103, exp_done: 125, sel: 1'b0};
        vecs[2] = '{hold: 5,   pct: 100, exp_first: 8,   exp_done: 30,  sel: 1'b0};
        vecs[3] = '{hold: 1,   pct: 30,  exp_first: 4,   exp_done: 0,   sel: 1'b0};
        vecs[4] = '{hold: 3,   pct: 60,  exp_first: 6,   exp_done: 0,   sel: 1'b1};
        vecs[5] = '{hold: 1,   pct: 100, exp_first: 4,   exp_done: 26,  sel: 1'b1};

        for (int a = 0; a < 256; a++) mem[a] = 16'h5500 | 16'(a);
        for (int i = 0; i < NW; i++) begin
            mem[(START_M + i) % 256] = 16'(16'h00A0 + i);
            mem[(START_W + i) % 256] = 16'(16'h00A0 + i);
        end

        rst = 1'b1; start = 1'b0; is_busy = 1'b0; m_ready = 1'b0; sel = 1'b0;
        ready_pct = 100;
        reset_track();
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(obs_busy), 32'd0);
        check("rst_valid", 32'(obs_valid), 32'd0);
        check("rst_err", 32'(obs_err), 32'd0);
        check("rst_ref", 32'(obs_ref), 32'd0);
        check("rst_done", 32'(obs_done), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        foreach (vecs[v]) run_job(vecs[v].hold, vecs[v].pct, vecs[v].exp_first, vecs[v].exp_done, vecs[v].sel);

        for (int r = 0; r < 4; r++) begin
            int h;
            h = $urandom_range(1, 6);
            run_job(h, $urandom_range(20, 90), h + 3, 0, 1'($urandom_range(0, 1)));
        end

        // Busy rises during CAP of pair 2: abort with sticky error, no completion.
        sel = 1'b0; reset_track(); ready_pct = 100; is_busy = 1'b0;
        pulse_start();
        for (int t = 1; t <= 11; t++) begin
            cycle_step(t);
            if (t == 11) is_busy = 1'b1;
            @(negedge clk);
        end
        check("abort_err", 32'(obs_err), 32'd1);
        check("abort_idle", 32'(obs_busy), 32'd0);
        check("abort_words", 32'(nrecv), 32'd4);
        is_busy = 1'b0;
        for (int t = 13; t <= 30; t++) begin
            @(negedge clk);
            cycle_step(t);
        end
        check("abort_no_done", 32'(done_cnt), 32'd0);
        check("abort_err_sticky", 32'(obs_err), 32'd1);
        run_job(1, 100, 4, 26, 1'b0);

        // Reset during SEND1 of pair 3, with an ignored extra start on the way.
        sel = 1'b0; reset_track(); ready_pct = 100; is_busy = 1'b0;
        pulse_start();
        for (int t = 1; t <= 17; t++) begin
            cycle_step(t);
            if (t == 8) start = 1'b1;
            if (t == 9) start = 1'b0;
            if (t == 17) rst = 1'b1;
            @(negedge clk);
        end
        check("rst_mid_words", 32'(nrecv), 32'd8);
        check("rst_mid_busy", 32'(obs_busy), 32'd0);
        check("rst_mid_valid", 32'(obs_valid), 32'd0);
        check("rst_mid_data", 32'(obs_data), 32'd0);
        check("rst_mid_idx", 32'(obs_idx), 32'd0);
        check("rst_mid_last", 32'(obs_last), 32'd0);
        check("rst_mid_ref", 32'(obs_ref), 32'd0);
        check("rst_mid_raddr1", 32'(obs_ra1), 32'd0);
        check("rst_mid_raddr2", 32'(obs_ra2), 32'd0);
        check("rst_mid_done", 32'(obs_done), 32'd0);
        check("rst_mid_err", 32'(obs_err), 32'd0);
        start = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("start_during_rst", 32'(obs_busy), 32'd0);
        for (int t = 0; t < 6; t++) begin
            @(negedge clk);
            cycle_step(100 + t);
        end
        check("rst_no_done", 32'(done_cnt), 32'd0);
        run_job(1, 100, 4, 26, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
